// File: rtl/bank_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : bank_req_queue
// Brief    : Per-bank circular request FIFO with an arbiter handshake FSM.
//            Each granted burst is capped at MAX_BURST pops. After a burst the
//            FSM inserts one HOLD cycle so that other banks get a turn.
//            Define BANK_REQ_QUEUE_ERR_EN to enable the sticky protocol checker.
// Revision : 1.0 - initial release
// ============================================================================
module bank_req_queue #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       ack,
    input  logic                       en,
    input  logic                       done,
    output logic                       req,
    output logic                       valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
    localparam logic [BW-1:0] C_MAX_BURST = BW'(MAX_BURST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [BW-1:0]     r_burst_cnt;
    logic [1:0]        r_state;
    logic              w_push;
    logic              w_pop;

    assign wr_ready = (r_count != C_DEPTH);
    assign count    = r_count;
    assign rd_data  = r_mem[r_rd_ptr];
    assign req      = (r_state == S_REQ) || (r_state == S_BURST);
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = en && valid;

    always_comb begin
        valid = 1'b0;
        case (r_state)
            S_REQ:   valid = 1'b1;
            S_BURST: valid = (r_count != '0) && (r_burst_cnt < C_MAX_BURST);
            default: valid = 1'b0;
        endcase
    end

    // Storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= S_REQ;
                        r_burst_cnt <= '0;
                    end
                end
                S_REQ: begin
                    // A pop in REQ is the first pop of the burst.
                    if (ack || en) r_state <= S_BURST;
                    if (w_pop) r_burst_cnt <= r_burst_cnt + BW'(1);
                end
                S_BURST: begin
                    if (w_pop && (r_burst_cnt != C_MAX_BURST))
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                    if (done && !valid) r_state <= S_HOLD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BANK_REQ_QUEUE_ERR_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((en && !valid && (r_state != S_HOLD)) ||
                     (wr_valid && !wr_ready) ||
                     (ack && (r_state != S_REQ))) begin
            r_err <= 1'b1;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
